// File: rtl/dot_vertical_ctrl.sv
// -----------------------------------------------------------------------------
// dot_vertical_ctrl
//   Vertical motion controller for the flappy dot. It takes the 'up' level from
//   flying_timer and moves the dot one discrete step per motion tick. While 'up'
//   is high the dot rises at a fixed rate. Otherwise it falls under gravity, with
//   a fall speed that grows by one row per step up to MAX_FALL. Reaching the
//   floor row ends the game.
//
// Ports
//   clk50_i       system clock (50 MHz)
//   reset_i       synchronous, active-high reset
//   up_i          1 = dot rises on the next step (sampled only on the step edge)
//   start_i       level; starts a game from IDLE, acknowledges game over in DEAD
//   y_pos_o       current dot row (row 0 = top of screen)
//   y_prev_o      dot row before the most recent step, used by the eraser
//   step_pulse_o  one-cycle strobe; y_pos_o/y_prev_o change in that same cycle
//   at_ceiling_o  y_pos_o == 0
//   game_over_o   high while the game is over (DEAD)
// -----------------------------------------------------------------------------
module dot_vertical_ctrl #(
  parameter int unsigned STEP_CYCLES = 2500000,
  parameter int unsigned CNT_W       = 22,
  parameter int unsigned Y_MAX       = 119,
  parameter int unsigned Y_START     = 60,
  parameter int unsigned RISE_STEP   = 1,
  parameter int unsigned MAX_FALL    = 3
) (
  input  logic       clk50_i,
  input  logic       reset_i,
  input  logic       up_i,
  input  logic       start_i,
  output logic [6:0] y_pos_o,
  output logic [6:0] y_prev_o,
  output logic       step_pulse_o,
  output logic       at_ceiling_o,
  output logic       game_over_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DEAD = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [7:0]       Y_MAX_W    = 8'(Y_MAX);
  localparam logic [6:0]       Y_MAX_7    = 7'(Y_MAX);
  localparam logic [6:0]       Y_START_7  = 7'(Y_START);
  localparam logic [7:0]       RISE_W     = 8'(RISE_STEP);
  localparam logic [6:0]       RISE_7     = 7'(RISE_STEP);
  localparam logic [3:0]       MAX_FALL_V = 4'(MAX_FALL);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       y_pos_q, y_pos_d;
  logic [6:0]       y_prev_q, y_prev_d;
  logic [3:0]       vel_q, vel_d;
  logic             pulse_q, pulse_d;

  // ---------------------------------------------------------------------------
  // Step arithmetic. Everything saturates to 0..Y_MAX; y never wraps.
  // ---------------------------------------------------------------------------
  logic       step_edge;
  logic [3:0] vel_inc, vel_next;
  logic [7:0] fall_sum;
  logic [6:0] fall_y, rise_y;
  logic       hits_floor;

  // The step fires on the same edge the tick counter wraps, so the first step
  // lands STEP_CYCLES cycles after entering PLAY.
  assign step_edge = (state_q == S_PLAY) && (cnt_q == CNT_LAST);

  // Gravity: speed grows by one row per falling step, capped at MAX_FALL.
  assign vel_inc  = vel_q + 4'd1;
  assign vel_next = (vel_inc > MAX_FALL_V) ? MAX_FALL_V : vel_inc;

  // The sum is formed in 8 bits so a position near 127 cannot wrap before
  // the floor clamp is applied.
  assign fall_sum   = {1'b0, y_pos_q} + {4'b0000, vel_next};
  assign fall_y     = (fall_sum >= Y_MAX_W) ? Y_MAX_7 : fall_sum[6:0];
  assign hits_floor = (fall_sum >= Y_MAX_W);

  // Rising into the ceiling clamps at row 0 and is harmless.
  assign rise_y = ({1'b0, y_pos_q} >= RISE_W) ? (y_pos_q - RISE_7) : 7'd0;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk50_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_PLAY;
      // Only a falling step can reach the floor; a rising step never does.
      S_PLAY: if (step_edge && !up_i && hits_floor) state_d = S_DEAD;
      // Holding start high auto-restarts: DEAD -> IDLE -> PLAY.
      S_DEAD: if (start_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    y_pos_d  = y_pos_q;
    y_prev_d = y_prev_q;
    vel_d    = vel_q;
    pulse_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        y_pos_d  = Y_START_7;
        y_prev_d = Y_START_7;
        vel_d    = 4'd0;
      end
      S_PLAY: begin
        if (step_edge) begin
          cnt_d    = '0;
          pulse_d  = 1'b1;
          y_prev_d = y_pos_q;
          if (up_i) begin
            vel_d   = 4'd0;
            y_pos_d = rise_y;
          end else begin
            vel_d   = vel_next;
            y_pos_d = fall_y;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DEAD: begin
        cnt_d = '0;
        // Position stays frozen for display until the player acknowledges.
        if (start_i) begin
          y_pos_d  = Y_START_7;
          y_prev_d = Y_START_7;
          vel_d    = 4'd0;
        end
      end
      default: begin
        cnt_d    = '0;
        y_pos_d  = Y_START_7;
        y_prev_d = Y_START_7;
        vel_d    = 4'd0;
      end
    endcase
  end

  always_comb begin
    game_over_o = (state_q == S_DEAD);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers. Reset wins over a coincident step edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk50_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      y_pos_q  <= Y_START_7;
      y_prev_q <= Y_START_7;
      vel_q    <= 4'd0;
      pulse_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      y_pos_q  <= y_pos_d;
      y_prev_q <= y_prev_d;
      vel_q    <= vel_d;
      pulse_q  <= pulse_d;
    end
  end

  assign y_pos_o      = y_pos_q;
  assign y_prev_o     = y_prev_q;
  assign step_pulse_o = pulse_q;
  assign at_ceiling_o = (y_pos_q == 7'd0);

endmodule

// File: tb/tb_dot_vertical_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dot_vertical_ctrl
//   Directed scenarios followed by random play, all checked every cycle against
//   a game-level reference model (mode, tick phase, height, fall speed).
// -----------------------------------------------------------------------------
module tb_dot_vertical_ctrl;

  localparam int SC = 4;
  localparam int YM = 15;
  localparam int YS = 8;
  localparam int RS = 1;
  localparam int MF = 3;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_DEAD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up = 1'b0;
  logic       start = 1'b0;
  logic [6:0] y_pos, y_prev;
  logic       step_pulse, at_ceiling, game_over;

  always #10 clk = ~clk;

  dot_vertical_ctrl #(
    .STEP_CYCLES(SC), .CNT_W(22), .Y_MAX(YM), .Y_START(YS),
    .RISE_STEP(RS), .MAX_FALL(MF)
  ) dut (
    .clk50_i      (clk),
    .reset_i      (reset),
    .up_i         (up),
    .start_i      (start),
    .y_pos_o      (y_pos),
    .y_prev_o     (y_prev),
    .step_pulse_o (step_pulse),
    .at_ceiling_o (at_ceiling),
    .game_over_o  (game_over)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_mode = M_IDLE;
  int m_phase = 0;
  int m_y = YS;
  int m_yprev = YS;
  int m_speed = 0;
  int m_pulse = 0;

  // heights observed at each step strobe
  int pos_q[$];
  int prev_q[$];
  int pulse_cnt = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One game tick of the reference: what the game looks like after an edge.
  task automatic model_edge(input bit r, input bit s, input bit u);
    m_pulse = 0;
    if (r) begin
      m_mode = M_IDLE; m_phase = 0; m_y = YS; m_yprev = YS; m_speed = 0;
    end else if (m_mode == M_IDLE) begin
      m_y = YS; m_yprev = YS; m_speed = 0; m_phase = 0;
      if (s) m_mode = M_PLAY;
    end else if (m_mode == M_PLAY) begin
      m_phase++;
      if (m_phase == SC) begin
        m_phase = 0;
        m_pulse = 1;
        m_yprev = m_y;
        if (u) begin
          m_speed = 0;
          m_y = (m_y - RS < 0) ? 0 : m_y - RS;
        end else begin
          m_speed = (m_speed + 1 > MF) ? MF : m_speed + 1;
          m_y = (m_y + m_speed > YM) ? YM : m_y + m_speed;
          if (m_y == YM) m_mode = M_DEAD;
        end
      end
    end else begin
      if (s) begin
        m_mode = M_IDLE; m_y = YS; m_yprev = YS; m_speed = 0;
      end
    end
  endtask

  // Apply inputs (we sit at a negedge), clock once, compare at the next negedge.
  task automatic cyc(input bit r, input bit s, input bit u);
    reset = r; start = s; up = u;
    @(posedge clk);
    model_edge(r, s, u);
    @(negedge clk);
    chk("y_pos",      int'(y_pos),      m_y);
    chk("y_prev",     int'(y_prev),     m_yprev);
    chk("step_pulse", int'(step_pulse), m_pulse);
    chk("at_ceiling", int'(at_ceiling), (m_y == 0) ? 1 : 0);
    chk("game_over",  int'(game_over),  (m_mode == M_DEAD) ? 1 : 0);
    if (step_pulse) begin
      pos_q.push_back(int'(y_pos));
      prev_q.push_back(int'(y_prev));
      pulse_cnt++;
    end
  endtask

  task automatic clear_log();
    pos_q.delete();
    prev_q.delete();
    pulse_cnt = 0;
  endtask

  initial begin
    int exp2[4];
    int exp4[4];
    int exp4p[4];
    int pat4[4];
    int wait_n;
    exp2  = '{9, 11, 14, 15};
    exp4  = '{9, 11, 10, 11};
    exp4p = '{8, 9, 11, 10};
    pat4  = '{0, 0, 1, 0};

    @(negedge clk);
    // 1: reset then idle; nothing moves
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("reset_y", int'(y_pos), YS);
    clear_log();
    for (int i = 0; i < 20; i++) cyc(0, 0, $urandom_range(0, 1));
    chk("idle_pulses", pulse_cnt, 0);
    chk("idle_over", int'(game_over), 0);

    // 2: free fall to the floor
    clear_log();
    cyc(0, 1, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 0);
    chk("fall_steps", pos_q.size(), 4);
    for (int i = 0; i < 4 && i < pos_q.size(); i++) chk("fall_y", pos_q[i], exp2[i]);
    chk("fall_over", int'(game_over), 1);
    chk("fall_frozen", int'(y_pos), YM);

    // 3: DEAD -> IDLE -> PLAY with start held, then climb to the ceiling
    clear_log();
    cyc(0, 1, 1);
    chk("ack_over", int'(game_over), 0);
    chk("ack_y", int'(y_pos), YS);
    cyc(0, 1, 1);
    for (int i = 0; i < 44; i++) cyc(0, 0, 1);
    chk("rise_steps", pos_q.size(), 11);
    for (int i = 0; i < pos_q.size(); i++)
      chk("rise_y", pos_q[i], (YS - 1 - i < 0) ? 0 : YS - 1 - i);
    chk("ceiling", int'(at_ceiling), 1);
    chk("rise_over", int'(game_over), 0);

    // 4: mixed up pattern; up only matters on the step edge
    cyc(1, 0, 0);
    clear_log();
    cyc(0, 1, 0);
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < SC; c++)
        cyc(0, 0, (c == SC - 1) ? pat4[k][0] : $urandom_range(0, 1));
    chk("mix_steps", pos_q.size(), 4);
    for (int i = 0; i < 4 && i < pos_q.size(); i++) begin
      chk("mix_y", pos_q[i], exp4[i]);
      chk("mix_prev", prev_q[i], exp4p[i]);
    end

    // 5: reset mid-play at phase 2, y=11
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("pre_rst_y", int'(y_pos), 11);
    cyc(1, 0, 0);
    chk("rst_mid_y", int'(y_pos), YS);
    clear_log();
    for (int i = 0; i < 12; i++) cyc(0, 0, 0);
    chk("rst_no_pulse", pulse_cnt, 0);

    // 6: die, then hold start; first strobe 4 cycles after entering PLAY
    cyc(0, 1, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 0);
    chk("die_again", int'(game_over), 1);
    cyc(0, 1, 0);
    chk("restart_over", int'(game_over), 0);
    chk("restart_y", int'(y_pos), YS);
    cyc(0, 1, 0);
    clear_log();
    wait_n = 0;
    while (pulse_cnt == 0 && wait_n < 20) begin
      cyc(0, 1, 0);
      wait_n++;
    end
    chk("first_step_lat", wait_n, SC);

    // random play
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 9) == 0),
          $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
